// File: rtl/ieee754_pkg.sv
// Shared IEEE 754 single-precision constants and the float-to-int FSM state type.
// Used by the unpack stage and the f2i converter; reusable by the adder/subtractor.
package ieee754_pkg;

  localparam int          EXP_BIAS     = 127;
  localparam logic [7:0]  EXP_SPECIAL  = 8'hFF;
  localparam int          MANT_W       = 23;
  localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
  // -2^31 is the only float at or beyond 2^31 in magnitude that still fits in int32
  localparam logic [31:0] F32_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} f2i_state_t;

endpackage

// File: rtl/ieee754_unpack.sv
// Splits a single-precision float into sign, exponent, {1,f} mantissa and class flags.
// Latency: combinational. Backpressure: none, pure function of the operand.
// The hidden bit is always set; callers handle zero/denormal via is_zero_or_denorm.
module ieee754_unpack
  import ieee754_pkg::*;
(
  input  logic [31:0]     a,
  output logic            sign,
  output logic [7:0]      exponent,
  output logic [MANT_W:0] mant,
  output logic            is_nan,
  output logic            is_inf,
  output logic            is_zero_or_denorm
);

  logic frac_nz;

  assign sign              = a[31];
  assign exponent          = a[30:23];
  assign mant              = {1'b1, a[MANT_W-1:0]};
  assign frac_nz           = |a[MANT_W-1:0];
  assign is_nan            = (exponent == EXP_SPECIAL) &&  frac_nz;
  assign is_inf            = (exponent == EXP_SPECIAL) && !frac_nz;
  assign is_zero_or_denorm = (exponent == 8'h00);

endmodule

// File: rtl/ieee754_f2i.sv
// Float32 to int32 converter with a one-bit-per-cycle alignment shifter.
// Latency: out_valid n+2 edges counting the accept edge (n = |u-23|, 0 for special classes).
// Backpressure: single-entry; in_ready only in IDLE, result held until out_ready. Macro: F2I_ROUND_NEAREST_EN.
module ieee754_f2i
  import ieee754_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        inexact
);

  f2i_state_t state, state_nxt;

  logic            sign;
  logic [7:0]      exponent;
  logic [MANT_W:0] mant;
  logic            is_nan, is_inf, is_zero_or_denorm;

  logic signed [8:0] u, u_off;
  logic [4:0]        shift_n;

  // Operand setup computed while IDLE, captured on the accept edge
  logic [31:0] ld_mag;
  logic        ld_guard, ld_sticky, ld_special, ld_sinv, ld_left;
  logic [31:0] ld_sres;
  logic [4:0]  ld_n;

  logic [31:0] mag, mag_rnd;
  logic        guard, sticky, sign_q, special, sinv, left;
  logic [31:0] sres;
  logic [4:0]  cnt;
  logic        rnd_inc;

  ieee754_unpack u_unpack (
    .a                 (a),
    .sign              (sign),
    .exponent          (exponent),
    .mant              (mant),
    .is_nan            (is_nan),
    .is_inf            (is_inf),
    .is_zero_or_denorm (is_zero_or_denorm)
  );

  assign u       = {1'b0, exponent} - 9'(EXP_BIAS);
  assign u_off   = u - 9'sd23;
  assign shift_n = u_off[8] ? 5'(-u_off) : 5'(u_off);

  always_comb begin
    ld_mag     = '0;
    ld_guard   = 1'b0;
    ld_sticky  = 1'b0;
    ld_special = 1'b0;
    ld_sinv    = 1'b0;
    ld_sres    = INT32_MAX;
    ld_left    = 1'b0;
    ld_n       = '0;
    if (is_nan) begin
      ld_special = 1'b1;
      ld_sinv    = 1'b1;
    end else if (is_inf) begin
      ld_special = 1'b1;
      ld_sinv    = 1'b1;
      ld_sres    = sign ? INT32_MIN : INT32_MAX;
    end else if (is_zero_or_denorm) begin
      ld_sticky  = |mant[MANT_W-1:0];
    end else if (u >= 9'sd31) begin
      ld_special = 1'b1;
      ld_sres    = sign ? INT32_MIN : INT32_MAX;
      ld_sinv    = (a != F32_NEG_2P31);
    end else if (u == -9'sd1) begin
      ld_guard   = 1'b1;
      ld_sticky  = |mant[MANT_W-1:0];
    end else if (u < -9'sd1) begin
      ld_sticky  = 1'b1;
    end else begin
      ld_mag     = {8'b0, mant};
      ld_left    = (u > 9'sd23);
      ld_n       = shift_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (ld_n != 5'd0) ? SHIFT : ROUND;
      SHIFT:   if (cnt == 5'd1) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

`ifdef F2I_ROUND_NEAREST_EN
  assign rnd_inc = guard & (sticky | mag[0]);
`else
  assign rnd_inc = 1'b0;
`endif
  // Cannot overflow: any rounded value has u <= 22, so mag < 2^23
  assign mag_rnd = mag + {31'b0, rnd_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag       <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      sign_q    <= 1'b0;
      special   <= 1'b0;
      sinv      <= 1'b0;
      sres      <= '0;
      left      <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag     <= ld_mag;
          guard   <= ld_guard;
          sticky  <= ld_sticky;
          sign_q  <= sign;
          special <= ld_special;
          sinv    <= ld_sinv;
          sres    <= ld_sres;
          left    <= ld_left;
          cnt     <= ld_n;
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          if (left) begin
            mag <= mag << 1;
          end else begin
            sticky <= sticky | guard;
            guard  <= mag[0];
            mag    <= mag >> 1;
          end
        end
        ROUND: begin
          out_valid <= 1'b1;
          if (special) begin
            result  <= sres;
            invalid <= sinv;
            inexact <= 1'b0;
          end else begin
            result  <= sign_q ? -mag_rnd : mag_rnd;
            invalid <= 1'b0;
            inexact <= guard | sticky;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
